slc3_input_conditioner: RTL
===========================

Name: slc3_input_conditioner

Overview:
Upstream front-end for the SLC-3 core. It conditions the raw board inputs (run button, continue button, 16 switches) before they reach the core's run_i, continue_i and sw_i, which expect inputs already synchronized at top level. It synchronizes every input into the clk domain and debounces the two buttons. It also stability-filters the switch bank, and provides both levels and one-cycle rising-edge pulses for the buttons.

Parameters:
SYNC_STAGES, 2, synchronizer flop depth per input bit; legal values are 2 and above.
DEBOUNCE_CYCLES, 100000, consecutive synchronized samples that must disagree with the debounced button level before that level flips; legal values are 1 and above.
SW_STABLE_CYCLES, 100000, consecutive unchanged synchronized switch samples required before sw_o updates; legal values are 1 and above.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
run_btn_i  input  1  raw run button, active-high, asynchronous and bouncy.
continue_btn_i  input  1  raw continue button, active-high, asynchronous and bouncy.
sw_raw_i  input  16  raw slide switches, asynchronous.
run_level_o  output  1  debounced run level, driven to the core's run_i.
continue_level_o  output  1  debounced continue level, driven to the core's continue_i.
run_pulse_o  output  1  one-cycle pulse on each rising edge of run_level_o.
continue_pulse_o  output  1  one-cycle pulse on each rising edge of continue_level_o.
sw_o  output  16  filtered switch value, driven to the core's sw_i.
sw_valid_o  output  1  high once sw_o has captured its first stable value.

Behaviour:
Reset:
- Asserted (reset=0): all synchronizer flops, counters and outputs clear to 0 immediately, without waiting for clk.
- Both button FSMs go to LOW.
- Release is used as-is; the block adds no reset synchronizer.

Synchronizers:
- Each input bit passes through a SYNC_STAGES-deep flop chain.
- Only the last stage is used by downstream logic.

Button debounce (one identical instance per button, each with its own counter):
- FSM states: LOW, CHK_HIGH, HIGH, CHK_LOW.
- LOW: level=0. A synchronized 1 moves to CHK_HIGH with count=1.
- CHK_HIGH: a synchronized 0 returns to LOW and clears count. A 1 increments count.
- Count reaching DEBOUNCE_CYCLES moves to HIGH. The level goes to 1 and the pulse goes to 1 on that same edge.
- HIGH and CHK_LOW mirror LOW and CHK_HIGH with polarity inverted. The falling level produces no pulse.
- Special case DEBOUNCE_CYCLES=1: the level flips on the first disagreeing sample.
- Latency: the level changes exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples a steady new raw value.
- The pulse is high for exactly one cycle per rising edge of the level. Bounce shorter than DEBOUNCE_CYCLES produces no change and no pulse.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never wraps because it is cleared on every state change.

Switch filter:
- A shadow register holds the previous synchronized vector.
- If the synchronized vector differs from the shadow (any bit), the shadow is loaded with it and the stability counter clears.
- Otherwise the counter increments and saturates at SW_STABLE_CYCLES.
- On the edge where the counter reaches SW_STABLE_CYCLES-1 with a matching sample, sw_o is loaded from the shadow and sw_valid_o is set.
- Latency: sw_o updates SYNC_STAGES+SW_STABLE_CYCLES edges after the raw vector settles.
- sw_valid_o stays set until reset. sw_o holds its value while the input is unstable.

Independence and reset:
- Simultaneous events on the two buttons and the switches are fully independent. Both pulses may assert in the same cycle.
- Reset mid-operation: everything returns to the reset state. A button still held after release is treated as a fresh press: it produces a full-latency level rise and a pulse.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, SW_STABLE_CYCLES=8.
1. Hold reset=0 with all raw inputs at 1 -> every output is 0. Release -> run_level_o and continue_level_o rise 6 edges later with one pulse each; sw_o becomes 16'hFFFF and sw_valid_o becomes 1 after 10 edges.
2. Clean press: run_btn_i=1 for 20 cycles, then 0 -> run_level_o rises 6 edges after the first sampling edge with run_pulse_o high for exactly 1 cycle; the level falls 6 edges after release with no pulse.
3. Bounce: continue_btn_i toggles every 2 cycles for 12 cycles, then stays at 1 -> exactly one continue_pulse_o, 6 edges after the last toggle; run outputs are unaffected.
4. Glitch: run_btn_i=1 for 3 cycles only -> run_level_o and run_pulse_o stay 0.
5. Switches: sw_raw_i=16'h1234 steady -> sw_o=16'h1234 after 10 edges. Then flip bit 0 every 5 cycles -> sw_o holds 16'h1234. Then set 16'hBEEF steady -> sw_o=16'hBEEF 10 edges later.
6. Press both buttons on the same edge -> both pulses high in the same cycle. Assert reset=0 at count 2 of a later press -> outputs clear asynchronously and no pulse is produced.

Source files
------------

// File: rtl/slc3_input_conditioner.sv
// SLC-3 input front-end: synchronizes raw board inputs, debounces the
// run/continue buttons and stability-filters the switch bank.
module slc3_input_conditioner #(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 100000,
    parameter int SW_STABLE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_btn_i,
    input  logic        continue_btn_i,
    input  logic [15:0] sw_raw_i,
    output logic        run_level_o,
    output logic        continue_level_o,
    output logic        run_pulse_o,
    output logic        continue_pulse_o,
    output logic [15:0] sw_o,
    output logic        sw_valid_o
);

    localparam int NB  = 18;
    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SCW = $clog2(SW_STABLE_CYCLES + 1);

    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic           DB_ONE  = (DEBOUNCE_CYCLES == 1);

    localparam logic [SCW-1:0] SW_MAX  = SCW'(SW_STABLE_CYCLES);
    localparam logic [SCW-1:0] SW_LAST =
        SCW'((SW_STABLE_CYCLES > 1) ? SW_STABLE_CYCLES - 2 : 0);
    localparam logic           SW_ONE  = (SW_STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_CHK_HIGH,
        ST_HIGH,
        ST_CHK_LOW
    } db_state_e;

    logic [SYNC_STAGES-1:0][NB-1:0] sync_q;
    logic [NB-1:0]                  sync_s;
    logic [1:0]                     btn_s;
    logic [1:0]                     level_w;
    logic [1:0]                     pulse_w;

    // Flop chain per input bit; only the last stage feeds the logic below
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {run_btn_i, continue_btn_i, sw_raw_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign btn_s  = sync_s[17:16];

    for (genvar b = 0; b < 2; b++) begin : g_db
        db_state_e      state_q;
        logic [DCW-1:0] cnt_q;
        logic           level_q;
        logic           pulse_q;

        // Debounce FSM: level flips after DEBOUNCE_CYCLES disagreeing samples
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_LOW;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                unique case (state_q)
                    ST_LOW: begin
                        if (btn_s[b]) begin
                            if (DB_ONE) begin
                                state_q <= ST_HIGH;
                                level_q <= 1'b1;
                                pulse_q <= 1'b1;
                            end else begin
                                state_q <= ST_CHK_HIGH;
                                cnt_q   <= DCW'(1);
                            end
                        end
                    end
                    ST_CHK_HIGH: begin
                        if (!btn_s[b]) begin
                            state_q <= ST_LOW;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (!btn_s[b]) begin
                            if (DB_ONE) begin
                                state_q <= ST_LOW;
                                level_q <= 1'b0;
                            end else begin
                                state_q <= ST_CHK_LOW;
                                cnt_q   <= DCW'(1);
                            end
                        end
                    end
                    ST_CHK_LOW: begin
                        if (btn_s[b]) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= ST_LOW;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign level_w[b] = level_q;
        assign pulse_w[b] = pulse_q;
    end

    assign run_level_o      = level_w[1];
    assign continue_level_o = level_w[0];
    assign run_pulse_o      = pulse_w[1];
    assign continue_pulse_o = pulse_w[0];

    logic [15:0]    sw_s;
    logic [15:0]    shadow_q;
    logic [15:0]    sw_q;
    logic [SCW-1:0] scnt_q;
    logic           sw_vld_q;
    logic           sw_match;
    logic           sw_load;

    assign sw_s     = sync_s[15:0];
    assign sw_match = (sw_s == shadow_q);
    assign sw_load  = SW_ONE | (sw_match & (scnt_q == SW_LAST));

    // Switch filter: publish the vector once it has held for SW_STABLE_CYCLES
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            scnt_q   <= '0;
            sw_q     <= '0;
            sw_vld_q <= 1'b0;
        end else begin
            if (!sw_match) begin
                shadow_q <= sw_s;
                scnt_q   <= '0;
            end else if (scnt_q != SW_MAX) begin
                scnt_q <= scnt_q + 1'b1;
            end
            if (sw_load) begin
                sw_q     <= sw_s;
                sw_vld_q <= 1'b1;
            end
        end
    end

    assign sw_o       = sw_q;
    assign sw_valid_o = sw_vld_q;

endmodule
